// File: rtl/tt_response_checker.sv
// Exhaustive truth-table response checker: sweeps x_out over every input code,
// samples f_in once per code and compares the captured table against EXPECTED.
module tt_response_checker #(
  parameter int                     N_IN     = 3,
  parameter int                     SETTLE   = 1,
  parameter logic [(1<<N_IN)-1:0]   EXPECTED = 8'hE8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [N_IN-1:0]      x_out,
  input  logic                 f_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [(1<<N_IN)-1:0] captured,
  output logic [N_IN:0]        mismatch_cnt,
  output logic                 err_valid,
  output logic [N_IN-1:0]      first_err_idx
);
  localparam int NC = 1 << N_IN;
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [N_IN-1:0] LAST = N_IN'(NC - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q;
  logic [N_IN-1:0] idx_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q, done_q, pass_q, errv_q;
  logic [NC-1:0]   cap_q;
  logic [N_IN:0]   mcnt_q, mcnt_d;
  logic [N_IN-1:0] ferr_q;
  logic            miss;

  // idx doubles as the driven code: x_out always equals the code being sampled
  assign miss   = (f_in != EXPECTED[idx_q]);
  assign mcnt_d = mcnt_q + {{N_IN{1'b0}}, miss};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      errv_q  <= 1'b0;
      cap_q   <= '0;
      mcnt_q  <= '0;
      ferr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_RUN;
            idx_q   <= '0;
            cnt_q   <= CW'(SETTLE);
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            errv_q  <= 1'b0;
            cap_q   <= '0;
            mcnt_q  <= '0;
            ferr_q  <= '0;
          end
        end
        S_RUN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            cap_q[idx_q] <= f_in;
            if (miss) begin
              mcnt_q <= mcnt_d;
              if (!errv_q) begin
                errv_q <= 1'b1;
                ferr_q <= idx_q;
              end
            end
            if (idx_q == LAST) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (mcnt_d == '0);
            end else begin
              idx_q <= idx_q + N_IN'(1);
              cnt_q <= CW'(SETTLE);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign x_out         = idx_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign captured      = cap_q;
  assign mismatch_cnt  = mcnt_q;
  assign err_valid     = errv_q;
  assign first_err_idx = ferr_q;
endmodule

// File: tb/tb_tt_response_checker.sv
// Bench for tt_response_checker: two instances (SETTLE=1 and SETTLE=0) driven by
// table-based model DUTs, checked against results derived from the table itself.
module tb_tt_response_checker;
  logic       clk, rst_n;
  logic       start_s [2];
  logic [2:0] x_s     [2];
  logic       f_s     [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       pass_s  [2];
  logic [7:0] cap_s   [2];
  logic [3:0] mc_s    [2];
  logic       ev_s    [2];
  logic [2:0] fe_s    [2];
  logic [7:0] tbl     [2];

  int n_chk, n_fail;

  localparam logic [7:0] GOLD = 8'hE8;

  assign f_s[0] = tbl[0][x_s[0]];
  assign f_s[1] = tbl[1][x_s[1]];

  tt_response_checker #(.N_IN(3), .SETTLE(1), .EXPECTED(8'hE8)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .x_out(x_s[0]), .f_in(f_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .captured(cap_s[0]),
    .mismatch_cnt(mc_s[0]), .err_valid(ev_s[0]), .first_err_idx(fe_s[0]));

  tt_response_checker #(.N_IN(3), .SETTLE(0), .EXPECTED(8'hE8)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .x_out(x_s[1]), .f_in(f_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .captured(cap_s[1]),
    .mismatch_cnt(mc_s[1]), .err_valid(ev_s[1]), .first_err_idx(fe_s[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, ".x_out"}, 32'(x_s[d]), 0);
    chk({tag, ".busy"}, 32'(busy_s[d]), 0);
    chk({tag, ".done"}, 32'(done_s[d]), 0);
    chk({tag, ".pass"}, 32'(pass_s[d]), 0);
    chk({tag, ".captured"}, 32'(cap_s[d]), 0);
    chk({tag, ".mismatch_cnt"}, 32'(mc_s[d]), 0);
    chk({tag, ".err_valid"}, 32'(ev_s[d]), 0);
    chk({tag, ".first_err_idx"}, 32'(fe_s[d]), 0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full sweep on instance d with model truth table t; hold keeps start high.
  task automatic sweep(input int d, input logic [7:0] t, input bit hold, input string tag);
    int         s    = (d == 0) ? 1 : 0;
    int         len  = 8 * (s + 1);
    logic [7:0] diff = t ^ GOLD;
    int         e_fe = 0;
    int         e_x;
    for (int i = 7; i >= 0; i--) if (diff[i]) e_fe = i;
    tbl[d] = t;
    @(negedge clk);
    start_s[d] = 1'b1;
    step();
    if (!hold) start_s[d] = 1'b0;
    chk({tag, ".x0"}, 32'(x_s[d]), 0);
    chk({tag, ".busy0"}, 32'(busy_s[d]), 1);
    chk({tag, ".done0"}, 32'(done_s[d]), 0);
    chk({tag, ".cap0"}, 32'(cap_s[d]), 0);
    for (int k = 1; k <= len; k++) begin
      step();
      e_x = k / (s + 1);
      if (e_x > 7) e_x = 7;
      chk($sformatf("%s.x@%0d", tag, k), 32'(x_s[d]), 32'(e_x));
      chk($sformatf("%s.busy@%0d", tag, k), 32'(busy_s[d]), (k < len) ? 1 : 0);
      chk($sformatf("%s.done@%0d", tag, k), 32'(done_s[d]), (k >= len) ? 1 : 0);
    end
    chk({tag, ".captured"}, 32'(cap_s[d]), 32'(t));
    chk({tag, ".mismatch_cnt"}, 32'(mc_s[d]), 32'($countones(diff)));
    chk({tag, ".err_valid"}, 32'(ev_s[d]), (diff != 0) ? 1 : 0);
    chk({tag, ".first_err_idx"}, 32'(fe_s[d]), 32'(e_fe));
    chk({tag, ".pass"}, 32'(pass_s[d]), (diff == 0) ? 1 : 0);
    if (!hold) begin
      step();
      chk({tag, ".done_level"}, 32'(done_s[d]), 1);
      chk({tag, ".x_hold"}, 32'(x_s[d]), 7);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    tbl[0] = GOLD; tbl[1] = GOLD;
    step(); step();
    chk_zero(0, "rst_s1");
    chk_zero(1, "rst_s0");
    rst_n = 1'b1;
    step();

    sweep(0, GOLD, 0, "golden");
    sweep(0, 8'hC8, 0, "x5inv");
    sweep(0, 8'h00, 0, "stuck0");
    sweep(1, GOLD, 0, "settle0");

    for (int r = 0; r < 6; r++) begin
      sweep(0, 8'($urandom), 0, $sformatf("rnd_s1_%0d", r));
      sweep(1, 8'($urandom), 0, $sformatf("rnd_s0_%0d", r));
    end

    // start held through a sweep: no mid-run restart, then restart from DONE
    sweep(0, 8'h0F, 1, "hold");
    step();
    chk("hold.restart_busy", 32'(busy_s[0]), 1);
    chk("hold.restart_done", 32'(done_s[0]), 0);
    chk("hold.restart_x", 32'(x_s[0]), 0);
    chk("hold.restart_cap", 32'(cap_s[0]), 0);
    chk("hold.restart_mc", 32'(mc_s[0]), 0);
    chk("hold.restart_ev", 32'(ev_s[0]), 0);
    chk("hold.restart_pass", 32'(pass_s[0]), 0);
    start_s[0] = 1'b0;

    // reset mid-sweep at x_out=4
    begin
      int guard = 0;
      while (x_s[0] != 3'd4 && guard < 40) begin
        step();
        guard++;
      end
      chk("midrst.reach_x4", 32'(x_s[0]), 4);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_zero(0, "midrst");
    step(); step(); step();
    chk("midrst.idle_x", 32'(x_s[0]), 0);
    chk("midrst.idle_busy", 32'(busy_s[0]), 0);
    sweep(0, GOLD, 0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
